int_freelist: RTL and testbench

Integer physical-register free list for the rename stage. It hands out free physical register indices (iprIdx_t) to rename lanes and takes back indices released at commit. It keeps a speculative allocation head and a committed allocation head, so a pipeline squash restores every allocation not yet committed in one cycle. It sits beside the rename map table: rename consumes from it, and the commit/ROB side returns registers to it.

---
 rtl/int_freelist_if.sv | 25 ++
 rtl/int_freelist.sv | 62 ++++++
 tb/tb_int_freelist.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/int_freelist_if.sv
// int_freelist_if: rename/commit-side port bundle of the integer free list.
interface int_freelist_if #(
  parameter int IPHYREG_NUM  = 64,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4
);
  localparam int IW = $clog2(IPHYREG_NUM);
  logic                              i_squash;
  logic [RENAME_WIDTH-1:0]           i_alloc_req;
  logic                              o_alloc_ready;
  logic [RENAME_WIDTH-1:0][IW-1:0]   o_alloc_prIdx;
  logic [$clog2(COMMIT_WIDTH+1)-1:0] i_commit_alloc_num;
  logic [COMMIT_WIDTH-1:0]           i_free_vld;
  logic [COMMIT_WIDTH-1:0][IW-1:0]   i_free_prIdx;
  logic [IW:0]                       o_free_num;
  logic                              o_overflow;
  modport master (
    output i_squash, i_alloc_req, i_commit_alloc_num, i_free_vld, i_free_prIdx,
    input  o_alloc_ready, o_alloc_prIdx, o_free_num, o_overflow
  );
  modport slave (
    input  i_squash, i_alloc_req, i_commit_alloc_num, i_free_vld, i_free_prIdx,
    output o_alloc_ready, o_alloc_prIdx, o_free_num, o_overflow
  );
endinterface

// File: rtl/int_freelist.sv
// int_freelist: circular free list of physical registers with speculative and committed allocation heads.
module int_freelist #(
  parameter int IPHYREG_NUM  = 64,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  int_freelist_if.slave fl
);
  localparam int IW   = $clog2(IPHYREG_NUM);
  localparam int PW   = IW + 1;
  localparam int INIT = IPHYREG_NUM - 32;
  logic [IW-1:0] buf_q [IPHYREG_NUM];
  logic [IW-1:0] buf_d [IPHYREG_NUM];
  logic [PW-1:0] spec_q, spec_d, arch_q, arch_d, tail_q, tail_d;
  logic [PW-1:0] free_num, req_cnt, vld_cnt;
  logic [RENAME_WIDTH-1:0][IW-1:0] alloc_idx;
  logic ovf_q, ovf_d, ready, fire;
  always_comb begin
    free_num = tail_q - spec_q;
    ready = free_num >= PW'(RENAME_WIDTH);
    req_cnt = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      alloc_idx[k] = buf_q[IW'(spec_q + req_cnt)];
      req_cnt = req_cnt + PW'(fl.i_alloc_req[k]);
    end
    fire = |fl.i_alloc_req & ready & !fl.i_squash;
    buf_d = buf_q;
    vld_cnt = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (fl.i_free_vld[k]) buf_d[IW'(tail_q + vld_cnt)] = fl.i_free_prIdx[k];
      vld_cnt = vld_cnt + PW'(fl.i_free_vld[k]);
    end
    arch_d = arch_q + PW'(fl.i_commit_alloc_num);
    // squash rewinds to the committed head including this cycle's commits
    spec_d = fl.i_squash ? arch_d : fire ? spec_q + req_cnt : spec_q;
    tail_d = tail_q + vld_cnt;
    ovf_d = ovf_q | (int'(free_num) + int'(vld_cnt) > INIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < IPHYREG_NUM; k++) buf_q[k] <= IW'(k + 32);
      spec_q <= '0;
      arch_q <= '0;
      tail_q <= PW'(INIT);
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      spec_q <= spec_d;
      arch_q <= arch_d;
      tail_q <= tail_d;
      ovf_q <= ovf_d;
    end
  end
  assign fl.o_alloc_ready = ready;
  assign fl.o_alloc_prIdx = alloc_idx;
  assign fl.o_free_num = free_num;
  assign fl.o_overflow = ovf_q;
  commit_le_uncommitted: assert property (@(posedge clk) disable iff (rst)
    PW'(fl.i_commit_alloc_num) <= PW'(spec_q - arch_q));
endmodule

// File: tb/tb_int_freelist.sv
// tb_int_freelist: queue-based reference model plus directed and random stimulus for int_freelist.
module tb_int_freelist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int freeq[$];
  int uncq[$];
  int owned[$];
  bit m_ovf = 1'b0;
  bit started = 1'b0;

  int_freelist_if fi();
  int_freelist dut (.clk(clk), .rst(rst), .fl(fi.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    freeq.delete();
    uncq.delete();
    owned.delete();
    for (int k = 32; k < 64; k++) freeq.push_back(k);
    for (int k = 0; k < 32; k++) owned.push_back(k);
    m_ovf = 1'b0;
  endtask

  // Model: free list as an ordered queue; uncommitted allocations kept aside for squash.
  always @(posedge clk) begin
    int n, nv;
    bit fire;
    if (rst) begin
      model_reset();
      started = 1'b1;
    end else if (started) begin
      n = $countones(fi.i_alloc_req);
      nv = $countones(fi.i_free_vld);
      fire = n > 0 && freeq.size() >= 4 && !fi.i_squash;
      if (freeq.size() + nv > 32) m_ovf = 1'b1;
      for (int k = 0; k < int'(fi.i_commit_alloc_num); k++)
        if (uncq.size() > 0) owned.push_back(uncq.pop_front());
      if (fi.i_squash) begin
        for (int k = uncq.size() - 1; k >= 0; k--) freeq.push_front(uncq[k]);
        uncq.delete();
      end
      if (fire) for (int k = 0; k < n; k++) uncq.push_back(freeq.pop_front());
      for (int l = 0; l < 4; l++) if (fi.i_free_vld[l]) freeq.push_back(int'(fi.i_free_prIdx[l]));
    end
  end

  always @(negedge clk) begin
    int p;
    if (started) begin
      chk("overflow", int'(fi.o_overflow), int'(m_ovf));
      if (!m_ovf) begin
        chk("free_num", int'(fi.o_free_num), freeq.size());
        chk("ready", int'(fi.o_alloc_ready), int'(freeq.size() >= 4));
        p = 0;
        for (int l = 0; l < 4; l++) if (fi.i_alloc_req[l]) begin
          if (p < freeq.size()) chk("alloc_prIdx", int'(fi.o_alloc_prIdx[l]), freeq[p]);
          p++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [3:0] req, input bit sq, input int cn);
    fi.i_alloc_req = req;
    fi.i_squash = sq;
    fi.i_commit_alloc_num = 3'(cn);
    fi.i_free_vld = '0;
    fi.i_free_prIdx = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set(4'b0000, 1'b0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic lanes(input string name, input int a, input int b, input int c, input int d);
    chk({name, "_l0"}, int'(fi.o_alloc_prIdx[0]), a);
    chk({name, "_l1"}, int'(fi.o_alloc_prIdx[1]), b);
    chk({name, "_l2"}, int'(fi.o_alloc_prIdx[2]), c);
    chk({name, "_l3"}, int'(fi.o_alloc_prIdx[3]), d);
  endtask

  initial begin
    set(4'b0000, 1'b0, 0);
    do_reset();
    // 1, 2: consecutive allocations in lane order
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c1_count", int'(fi.o_free_num), 32);
    lanes("c1", 32, 33, 34, 35);
    tick();
    set(4'b1010, 1'b0, 0);
    @(negedge clk);
    chk("c1_count_after", int'(fi.o_free_num), 28);
    chk("c1_ready_after", int'(fi.o_alloc_ready), 1);
    chk("c2_l1", int'(fi.o_alloc_prIdx[1]), 36);
    chk("c2_l3", int'(fi.o_alloc_prIdx[3]), 37);
    tick();
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c2_count", int'(fi.o_free_num), 26);
    lanes("c2", 38, 39, 40, 41);
    tick();
    // 3: drain, hold, refill
    do_reset();
    set(4'b1111, 1'b0, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("c3_empty", int'(fi.o_free_num), 0);
    chk("c3_not_ready", int'(fi.o_alloc_ready), 0);
    tick();
    @(negedge clk);
    chk("c3_hold", int'(fi.o_free_num), 0);
    set(4'b0000, 1'b0, 0);
    fi.i_free_vld = 4'b1111;
    fi.i_free_prIdx = {6'd41, 6'd40, 6'd9, 6'd5};
    tick();
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c3_refill", int'(fi.o_free_num), 4);
    chk("c3_ready", int'(fi.o_alloc_ready), 1);
    lanes("c3", 5, 9, 40, 41);
    tick();
    // 4: squash restores uncommitted allocations
    do_reset();
    set(4'b1111, 1'b0, 0);
    repeat (2) tick();
    set(4'b0000, 1'b0, 4);
    tick();
    set(4'b0000, 1'b1, 0);
    tick();
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c4_count", int'(fi.o_free_num), 28);
    lanes("c4", 36, 37, 38, 39);
    tick();
    // 5: squash with same-cycle commit and a suppressed request
    do_reset();
    set(4'b1111, 1'b0, 0);
    repeat (2) tick();
    set(4'b1111, 1'b1, 2);
    tick();
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c5_count", int'(fi.o_free_num), 30);
    lanes("c5", 34, 35, 36, 37);
    tick();
    // 6: overflow is sticky until reset
    do_reset();
    set(4'b0000, 1'b0, 0);
    fi.i_free_vld = 4'b0001;
    fi.i_free_prIdx[0] = 6'd7;
    tick();
    set(4'b0000, 1'b0, 0);
    @(negedge clk);
    chk("c6_ovf", int'(fi.o_overflow), 1);
    repeat (2) tick();
    @(negedge clk);
    chk("c6_ovf_sticky", int'(fi.o_overflow), 1);
    do_reset();
    set(4'b1111, 1'b0, 0);
    @(negedge clk);
    chk("c6_ovf_clear", int'(fi.o_overflow), 0);
    chk("c6_count", int'(fi.o_free_num), 32);
    lanes("c6", 32, 33, 34, 35);
    tick();
    // random traffic that respects the commit and capacity rules
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int cn, avail, need, j;
      rst = ($urandom_range(0, 299) == 0);
      fi.i_alloc_req = 4'($urandom);
      fi.i_squash = ($urandom_range(0, 11) == 0);
      cn = $urandom_range(0, uncq.size() < 4 ? uncq.size() : 4);
      fi.i_commit_alloc_num = 3'(cn);
      avail = owned.size() - 32;
      if (avail > 4) avail = 4;
      need = $urandom_range(0, avail);
      fi.i_free_vld = '0;
      for (int l = 0; l < 4; l++) begin
        fi.i_free_prIdx[l] = 6'($urandom);
        if (need > 0 && ($urandom_range(0, 1) == 1 || 4 - l == need)) begin
          j = $urandom_range(0, owned.size() - 1);
          fi.i_free_prIdx[l] = 6'(owned[j]);
          owned.delete(j);
          fi.i_free_vld[l] = 1'b1;
          need--;
        end
      end
      tick();
    end
    rst = 1'b0;
    set(4'b0000, 1'b0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
